// File: rtl/complex_pkg.sv
// Shared definitions for the complex multiply/accumulate datapath.
// COMPLEX_T declares a packed {imag, real} pair whose width depends on a parameter.
`ifndef COMPLEX_PKG_SV
`define COMPLEX_PKG_SV

`define COMPLEX_T(NAME, W) \
    typedef struct packed { \
        logic signed [(W)-1:0] im; \
        logic signed [(W)-1:0] re; \
    } NAME;

package complex_pkg;

    localparam int DEFAULT_INTEGER_WIDTH    = 8;
    localparam int DEFAULT_FRACTIONAL_WIDTH = 8;
    localparam int OPERAND_WIDTH            = DEFAULT_INTEGER_WIDTH + DEFAULT_FRACTIONAL_WIDTH;
    localparam int PROD_WIDTH               = 2 * OPERAND_WIDTH;

    // Guard bits let len full-scale products be summed without overflow.
    function automatic int acc_width(input int prod_w, input int len);
        return prod_w + $clog2(len);
    endfunction

endpackage

`endif

// File: rtl/complex_accumulator_if.sv
// AXI-Stream style valid/ready/data bundle used for both accumulator ports.
interface complex_accumulator_if #(
    parameter int WIDTH = 64
);

    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/complex_accumulator.sv
// Sums ACC_LEN consecutive complex products into one full-precision result beat.
// The sum is computed combinationally so the terminal beat adds straight into the output register.
module complex_accumulator
    import complex_pkg::*;
#(
    parameter int INTEGER_WIDTH    = DEFAULT_INTEGER_WIDTH,
    parameter int FRACTIONAL_WIDTH = DEFAULT_FRACTIONAL_WIDTH,
    parameter int ACC_LEN          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    complex_accumulator_if.slave  i_prod,
    complex_accumulator_if.master o_acc
);

    localparam int PW = 2 * (INTEGER_WIDTH + FRACTIONAL_WIDTH);
    localparam int AW = acc_width(PW, ACC_LEN);
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_LEN - 1);

    generate
        if (ACC_LEN < 1) begin : g_badAccLen
            $error("complex_accumulator: ACC_LEN must be >= 1");
        end
    endgenerate

    `COMPLEX_T(prod_t, PW)
    `COMPLEX_T(acc_t, AW)

    prod_t         w_prod;
    acc_t          w_sum;
    logic          w_ready;
    logic          w_accept;
    logic          w_terminal;
    logic          w_outFire;

    acc_t          r_acc;
    acc_t          r_out;
    logic          r_outValid;
    logic [CW-1:0] r_count;

    // Input stalls only while a finished result is still waiting for the sink.
    assign w_ready    = !r_outValid || o_acc.tready;
    assign w_accept   = i_prod.tvalid && w_ready;
    assign w_terminal = w_accept && (r_count == LAST_BEAT);
    assign w_outFire  = r_outValid && o_acc.tready;
    assign w_prod     = i_prod.tdata;

    always_comb begin
        w_sum    = '0;
        w_sum.re = r_acc.re + AW'($signed(w_prod.re));
        w_sum.im = r_acc.im + AW'($signed(w_prod.im));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            if (w_terminal) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + CW'(1);
            end
        end
    end

    // A new terminal beat takes priority over draining, so back-to-back results keep tvalid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_terminal) begin
            r_out      <= w_sum;
            r_outValid <= 1'b1;
        end else if (w_outFire) begin
            r_outValid <= 1'b0;
        end
    end

    assign i_prod.tready = w_ready;
    assign o_acc.tvalid  = r_outValid;
    assign o_acc.tdata   = r_out;

endmodule

// File: tb/tb_complex_accumulator.sv
// Drives an ACC_LEN=4 and an ACC_LEN=1 accumulator from one product stream and checks
// both every cycle against a queue-based model of group sums.
module tb_complex_accumulator;

    typedef logic signed [63:0] val_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inValid = 1'b0;
    logic outReady = 1'b1;
    val_t inRe = '0;
    val_t inIm = '0;

    int assertCount = 0;
    int failCount = 0;

    val_t partRe[2];
    val_t partIm[2];
    int   beatCount[2];
    val_t pendRe[2][$];
    val_t pendIm[2][$];
    val_t logRe[2][$];
    val_t logIm[2][$];

    always #5 clk = ~clk;

    complex_accumulator_if #(.WIDTH(64)) prod0 ();
    complex_accumulator_if #(.WIDTH(68)) acc0 ();
    complex_accumulator_if #(.WIDTH(64)) prod1 ();
    complex_accumulator_if #(.WIDTH(64)) acc1 ();

    assign prod0.tvalid = inValid;
    assign prod0.tdata  = {inIm[31:0], inRe[31:0]};
    assign prod1.tvalid = inValid;
    assign prod1.tdata  = {inIm[31:0], inRe[31:0]};
    assign acc0.tready  = outReady;
    assign acc1.tready  = outReady;

    complex_accumulator #(.INTEGER_WIDTH(8), .FRACTIONAL_WIDTH(8), .ACC_LEN(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_prod (prod0),
        .o_acc  (acc0)
    );

    complex_accumulator #(.INTEGER_WIDTH(8), .FRACTIONAL_WIDTH(8), .ACC_LEN(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_prod (prod1),
        .o_acc  (acc1)
    );

    function automatic int lenOf(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic checkOutput(input string name, input val_t actual, input val_t expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic getActual(input int d, output val_t v, output val_t r, output val_t re, output val_t im);
        if (d == 0) begin
            v  = val_t'(acc0.tvalid);
            r  = val_t'(prod0.tready);
            re = val_t'($signed(acc0.tdata[33:0]));
            im = val_t'($signed(acc0.tdata[67:34]));
        end else begin
            v  = val_t'(acc1.tvalid);
            r  = val_t'(prod1.tready);
            re = val_t'($signed(acc1.tdata[31:0]));
            im = val_t'($signed(acc1.tdata[63:32]));
        end
    endtask

    // Model: accepted beats are grouped lenOf(d) at a time; each finished group waits in a queue until the sink takes it.
    always @(negedge clk) begin
        val_t aValid, aReady, aRe, aIm;
        bit expReady, fire, accept;
        for (int d = 0; d < 2; d++) begin
            getActual(d, aValid, aReady, aRe, aIm);
            if (!rst_n) begin
                checkOutput($sformatf("dut%0d reset tvalid", d), aValid, 0);
                checkOutput($sformatf("dut%0d reset tdata.re", d), aRe, 0);
                checkOutput($sformatf("dut%0d reset tdata.im", d), aIm, 0);
                partRe[d] = 0;
                partIm[d] = 0;
                beatCount[d] = 0;
                pendRe[d].delete();
                pendIm[d].delete();
            end else begin
                expReady = (pendRe[d].size() == 0) || outReady;
                checkOutput($sformatf("dut%0d input tready", d), aReady, val_t'(expReady));
                checkOutput($sformatf("dut%0d output tvalid", d), aValid, val_t'(pendRe[d].size() != 0));
                if (pendRe[d].size() != 0) begin
                    checkOutput($sformatf("dut%0d tdata.re", d), aRe, pendRe[d][0]);
                    checkOutput($sformatf("dut%0d tdata.im", d), aIm, pendIm[d][0]);
                end
                fire = (pendRe[d].size() != 0) && outReady;
                accept = inValid && expReady;
                if (fire) begin
                    void'(pendRe[d].pop_front());
                    void'(pendIm[d].pop_front());
                end
                if (accept) begin
                    partRe[d] += inRe;
                    partIm[d] += inIm;
                    beatCount[d]++;
                    if (beatCount[d] == lenOf(d)) begin
                        pendRe[d].push_back(partRe[d]);
                        pendIm[d].push_back(partIm[d]);
                        logRe[d].push_back(partRe[d]);
                        logIm[d].push_back(partIm[d]);
                        partRe[d] = 0;
                        partIm[d] = 0;
                        beatCount[d] = 0;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input val_t re, input val_t im);
        bit accepted;
        inRe = re;
        inIm = im;
        inValid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = (prod0.tready === 1'b1) && rst_n;
            @(posedge clk);
            #1;
        end
        checkOutput("input handshake", val_t'(accepted), 1);
        inValid = 1'b0;
    endtask

    task automatic checkLog(input int d, input string name, input val_t re, input val_t im);
        if (logRe[d].size() == 0) begin
            checkOutput({name, " result produced"}, 0, 1);
        end else begin
            checkOutput({name, " model re"}, logRe[d].pop_front(), re);
            checkOutput({name, " model im"}, logIm[d].pop_front(), im);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);

        repeat (4) applyStimulus(65536, -32768);
        idle(2);
        checkLog(0, "basic", 262144, -131072);

        for (int i = 1; i <= 8; i++) applyStimulus(val_t'(i), 0);
        idle(2);
        checkLog(0, "b2b first", 10, 0);
        checkLog(0, "b2b second", 26, 0);

        for (int i = 1; i <= 4; i++) applyStimulus(val_t'(i), val_t'(i));
        outReady = 1'b0;
        fork
            applyStimulus(5, 5);
            begin
                idle(5);
                outReady = 1'b1;
            end
        join
        for (int i = 6; i <= 8; i++) applyStimulus(val_t'(i), val_t'(i));
        idle(2);
        checkLog(0, "backpressure first", 10, 10);
        checkLog(0, "backpressure second", 26, 26);

        repeat (4) applyStimulus(-64'sd2147483648, -64'sd2147483648);
        repeat (4) applyStimulus(64'sd2147483647, 64'sd2147483647);
        idle(2);
        checkLog(0, "most negative", -64'sd8589934592, -64'sd8589934592);
        checkLog(0, "most positive", 64'sd8589934588, 64'sd8589934588);

        repeat (2) applyStimulus(100, 0);
        idle(1);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        repeat (4) applyStimulus(1, 0);
        idle(2);
        checkLog(0, "after reset", 4, 0);

        logRe[1].delete();
        logIm[1].delete();
        repeat (4) applyStimulus(-7, 3);
        idle(2);
        for (int i = 0; i < 4; i++) checkLog(1, $sformatf("len1 beat %0d", i), -7, 3);
        checkLog(0, "len4 of -7/3", -28, 12);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
